// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit with architectural HI/LO registers
//   clk, rst (async active-high)           clock and reset
//   start, op[2:0], a, b                   request: 000 MULT 001 MULTU 010 DIV 011 DIVU 100 MTHI 101 MTLO
//   cancel                                 flush of the in-flight operation
//   busy, done, hi, lo                     status pulse outputs and HI/LO registers
module mdu_hilo #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   md_q, md_d, hi_q, hi_d, lo_q, lo_d;
    logic               div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, done_q, done_d;
    logic               accept, sgn;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
    logic [WIDTH:0]     msum, rsh, rdiff;
    logic [2*WIDTH-1:0] prod;
    assign accept = start && !cancel && state_q == IDLE;
    assign sgn    = !op[0];
    assign a_mag  = sgn && a[WIDTH-1] ? -a : a;
    assign b_mag  = sgn && b[WIDTH-1] ? -b : b;
    // acc holds {partial product, multiplier} for mult and {remainder, quotient} for div
    assign msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? md_q : '0};
    assign rsh    = acc_q[2*WIDTH-1:WIDTH-1];
    assign rdiff  = rsh - {1'b0, md_q};
    assign prod   = neg_q ? -acc_q : acc_q;
    assign quo    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        md_d    = md_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        if (accept && !op[2]) begin
            state_d = RUN;
            cnt_d   = '0;
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            md_d    = b_mag;
            div_d   = op[1];
            // a zero divisor keeps the quotient unnegated so it reads all-ones and hi reads a
            neg_d   = sgn && (a[WIDTH-1] ^ b[WIDTH-1]) && (!op[1] || |b);
            rneg_d  = sgn && op[1] && a[WIDTH-1];
        end else if (accept && op == 3'b100) begin
            hi_d = a;
        end else if (accept && op == 3'b101) begin
            lo_d = a;
        end else if (state_q == RUN) begin
            state_d = cancel ? IDLE : (cnt_q == CNT_W'(WIDTH - 1) ? FIN : RUN);
            cnt_d   = cnt_q + 1'b1;
            acc_d   = div_q ? (rdiff[WIDTH] ? {rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                            : {rdiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1})
                            : {msum, acc_q[WIDTH-1:1]};
        end else if (state_q == FIN) begin
            state_d = IDLE;
            hi_d    = cancel ? hi_q : (div_q ? rem : prod[2*WIDTH-1:WIDTH]);
            lo_d    = cancel ? lo_q : (div_q ? quo : prod[WIDTH-1:0]);
            done_d  = !cancel;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            md_q    <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            md_q    <= md_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end
    assign busy = state_q != IDLE;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: self-checking bench for mdu_hilo against an arithmetic reference model
module tb_mdu_hilo;
    logic        clk = 0, rst = 0, start = 0, cancel = 0;
    logic [2:0]  op = 0;
    logic [31:0] a = 0, b = 0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          tests = 0, failures = 0;
    logic [31:0] exp_hi = 0, exp_lo = 0;

    mdu_hilo dut (.clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
                  .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, got, expv);
        end
    endtask

    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, r;
        logic [63:0] ux, uy, ur;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'b0, x};
        uy = {32'b0, y};
        if (o == 3'd0) begin
            r = sx * sy;
            {exp_hi, exp_lo} = r;
        end else if (o == 3'd1) begin
            ur = ux * uy;
            {exp_hi, exp_lo} = ur;
        end else if (y == 0) begin
            exp_lo = 32'hFFFF_FFFF;
            exp_hi = x;
        end else if (o == 3'd2) begin
            r = sx / sy;
            exp_lo = r[31:0];
            r = sx % sy;
            exp_hi = r[31:0];
        end else begin
            exp_lo = x / y;
            exp_hi = x % y;
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int n;
        check("idle_before", {31'b0, busy}, 0);
        start = 1; op = o; a = x; b = y;
        tick();
        start = 0; a = $urandom; b = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            check("hold_hi", hi, exp_hi);
            check("hold_lo", lo, exp_lo);
            check("no_done_while_busy", {31'b0, done}, 0);
            tick();
            n++;
        end
        check("busy_cycles", n, 33);
        model(o, x, y);
        check("done_pulse", {31'b0, done}, 1);
        check("result_hi", hi, exp_hi);
        check("result_lo", lo, exp_lo);
    endtask

    initial begin
        #1 rst = 1;
        #1;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        tick();
        rst = 0;
        tick();

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3);
        check("mult_hi_const", hi, 32'hFFFF_FFFF);
        check("mult_lo_const", lo, 32'hFFFF_FFFA);
        tick();
        check("done_one_cycle", {31'b0, done}, 0);
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3);
        check("multu_hi_const", hi, 32'h0000_0002);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        check("div_lo_const", lo, 32'hFFFF_FFFD);
        run_op(3'd3, 32'd7, 32'd0);
        check("divu0_hi_const", hi, 32'd7);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo_const", lo, 32'h8000_0000);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd0);
        tick();

        start = 1; op = 3'd4; a = 32'h1234_5678;
        tick();
        exp_hi = 32'h1234_5678;
        check("mthi_hi", hi, exp_hi);
        check("mthi_lo", lo, exp_lo);
        check("mthi_busy", {31'b0, busy}, 0);
        op = 3'd5; a = 32'h9ABC_DEF0;
        tick();
        exp_lo = 32'h9ABC_DEF0;
        check("mtlo_lo", lo, exp_lo);
        check("mtlo_hi", hi, exp_hi);
        check("mtlo_busy", {31'b0, busy}, 0);
        check("mtlo_done", {31'b0, done}, 0);
        op = 3'd4; a = 32'hDEAD_BEEF; cancel = 1;
        tick();
        check("cancel_idle_hi", hi, exp_hi);
        check("cancel_idle_busy", {31'b0, busy}, 0);
        cancel = 0; op = 3'd6; a = 32'h1111_1111; b = 32'h2;
        tick();
        start = 0;
        check("reserved_busy", {31'b0, busy}, 0);
        check("reserved_hi", hi, exp_hi);
        check("reserved_lo", lo, exp_lo);

        start = 1; op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        tick();
        start = 0;
        for (int i = 1; i < 10; i++) begin
            start = (i == 4);
            a = 32'd5; b = 32'd6;
            tick();
        end
        start = 0;
        check("cancel_busy_before", {31'b0, busy}, 1);
        cancel = 1;
        tick();
        cancel = 0;
        check("cancel_busy_after", {31'b0, busy}, 0);
        for (int i = 0; i < 40; i++) begin
            check("cancel_no_done", {31'b0, done}, 0);
            check("cancel_hi", hi, exp_hi);
            check("cancel_lo", lo, exp_lo);
            tick();
        end

        start = 1; op = 3'd3; a = 32'd1000; b = 32'd3;
        tick();
        start = 0;
        repeat (5) tick();
        #2 rst = 1;
        #1;
        exp_hi = 0; exp_lo = 0;
        check("arst_busy", {31'b0, busy}, 0);
        check("arst_done", {31'b0, done}, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        #3 rst = 0;
        tick();
        run_op(3'd3, 32'd100, 32'd7);
        check("divu_lo_const", lo, 32'd14);
        check("divu_hi_const", hi, 32'd2);

        for (int i = 0; i < 12; i++) begin
            logic [2:0]  o;
            logic [31:0] x, y;
            o = 3'($urandom_range(0, 3));
            x = $urandom;
            y = (i % 4 == 3) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(1, 300)) : $urandom);
            if (i % 5 == 2) y = -y;
            run_op(o, x, y);
        end
        tick();
        check("final_done_low", {31'b0, done}, 0);
        check("final_busy_low", {31'b0, busy}, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the ALU in EX, directly upstream of the register file.
- MFHI/MFLO write-back data is taken from the hi/lo outputs into the register-file write-data mux.
- The busy output stalls the pipeline front-end.

Parameters:
- WIDTH, 32, operand/HI/LO width. Must equal the register-file word width.
- CNT_W, 5, iteration counter width. 2^CNT_W must equal WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x ignored
- a  input  WIDTH  rs operand / dividend / MTHI-MTLO source
- b  input  WIDTH  rt operand / divisor
- cancel  input  1  exception flush; aborts the in-flight operation
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse in the cycle after HI/LO are updated by mult/div
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy=0, done=0, hi=0, lo=0, counter and internal accumulators cleared. Applies at any time, including mid-operation; no result is written.
- FSM states:
  - IDLE -> RUN on an accepted mult/div start.
  - RUN stays for WIDTH iteration edges, then -> FIN.
  - FIN -> IDLE on the next edge.
- busy = (state != IDLE). It is a registered-state decode, so it has no combinational path from start.
- Accept rule: start=1, busy=0, cancel=0 at edge k.
- MTHI/MTLO:
  - Single-cycle; hi (or lo) <= a at edge k.
  - No busy, no done.
  - The other register is unchanged.
- Mult/div timing for an operation accepted at edge k:
  - Operands are latched at edge k.
  - Iterations run at edges k+1..k+WIDTH.
  - At edge k+WIDTH+1 (FIN), hi/lo are written and state returns to IDLE.
  - done=1 for exactly the one cycle following edge k+WIDTH+1.
  - busy is high for WIDTH+1 cycles.
  - The earliest next accept is edge k+WIDTH+2.
- Multiply:
  - Radix-2 shift-add on operand magnitudes, producing a 2*WIDTH-bit product.
  - MULT negates the product if sign(a) != sign(b).
  - Result: hi = product[2W-1:W], lo = product[W-1:0].
- Divide:
  - Restoring division on magnitudes.
  - lo = quotient, hi = remainder.
  - DIV: the quotient is negated if signs differ; the remainder takes the sign of the dividend.
  - Divisor = 0, both DIV and DIVU: lo = all-ones, hi = a.
  - DIV of most-negative by -1: lo = 0x8000_0000, hi = 0. This falls out of the magnitude path without any special case.
- hi/lo hold their old values for the whole of RUN/FIN. Intermediate values live only in internal registers.
- Start while busy=1: ignored, with no queuing.
- Reserved op (11x) with start: ignored; state stays IDLE.
- Cancel:
  - cancel=1 in RUN or FIN -> IDLE at the next edge.
  - hi/lo unchanged, no done pulse.
  - cancel with start in IDLE: cancel wins and nothing is accepted, including MTHI/MTLO.
- done is never asserted together with busy.

Test Plan:
- Reset, then MULT with a=0xFFFF_FFFE, b=3 -> after 33 busy cycles, done pulse; hi=0xFFFF_FFFF, lo=0xFFFF_FFFA. MULTU with the same operands -> hi=0x0000_0002, lo=0xFFFF_FFFA.
- DIV with a=0xFFFF_FFF9 (-7), b=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU with a=7, b=0 -> lo=0xFFFF_FFFF, hi=7. DIV with a=0x8000_0000, b=0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- MTHI with a=0x1234_5678, then MTLO with a=0x9ABC_DEF0 on consecutive cycles -> hi/lo update on each edge; busy stays 0; no done.
- Start MULTU with a=b=0xFFFF_FFFF; assert cancel on the 10th busy cycle -> busy=0 next cycle; hi/lo retain prior values; no done. A second start with a new MULTU during busy is ignored and its result never appears.
- Assert rst asynchronously mid-DIVU (between clock edges) -> busy, done, hi and lo go to 0 immediately. After release, a DIVU with a=100, b=7 gives lo=14, hi=2.
- Back-to-back: start a new MULT at the first edge where busy=0 after the previous operation -> accepted; done of the first operation and busy of the second occur in different cycles with no overlap.
